// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared defaults and config record for the programmable sequence detector
package seq_det_pkg;
  localparam int PAT_W = 32;
  localparam int CFG_LEN_W = 6;
  localparam logic [PAT_W-1:0] DEF_PAT = 32'b101;
  localparam logic [CFG_LEN_W-1:0] DEF_LEN = 6'd3;
  localparam logic DEF_OVERLAP = 1'b1;
  typedef struct packed {
    logic [PAT_W-1:0] pattern;
    logic [CFG_LEN_W-1:0] len;
    logic overlap;
  } cfg_t;
endpackage

// File: rtl/seq_det_sat_cnt.sv
// seq_det_sat_cnt: saturating up-counter, clear has priority over increment
// ports: clock_in, rst_in (sync, active-low), clr, inc, count[CNT_W]
module seq_det_sat_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clock_in,
  input  logic             rst_in,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  always_ff @(posedge clock_in)
    if (!rst_in || clr) count <= '0;
    else if (inc && count != '1) count <= count + CNT_W'(1);
endmodule

// File: rtl/seq_det_prog.sv
// seq_det_prog: runtime-programmable serial pattern detector with saturating match counter
// ports: clock_in, rst_in (sync, active-low); cfg_load/cfg_pattern/cfg_len/cfg_overlap -> cfg_err;
//        data_valid/data_in -> match_out; cnt_clr -> match_count
module seq_det_prog
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int CNT_W = 8,
  localparam int LEN_W = $clog2(MAX_LEN + 1)
) (
  input  logic               clock_in,
  input  logic               rst_in,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               cfg_err,
  input  logic               data_valid,
  input  logic               data_in,
  output logic               match_out,
  input  logic               cnt_clr,
  output logic [CNT_W-1:0]   match_count
);
  cfg_t cfg_q;
  logic [MAX_LEN-1:0] hist, nxt;
  logic [LEN_W-1:0] fill, fill_inc;
  logic [PAT_W-1:0] mask;
  logic hit, take, len_ok;
  always_comb begin
    nxt = {hist[MAX_LEN-2:0], data_in};
    // shifting by the full width yields zero, so len == 32 gives an all-ones mask
    mask = ~({PAT_W{1'b1}} << cfg_q.len);
    hit = (7'(fill) + 7'd1 >= 7'(cfg_q.len)) && (((PAT_W'(nxt) ^ cfg_q.pattern) & mask) == '0);
    take = data_valid && !cfg_load && hit;
    len_ok = cfg_len != '0 && cfg_len <= LEN_W'(MAX_LEN);
    fill_inc = (fill == LEN_W'(MAX_LEN)) ? fill : fill + LEN_W'(1);
  end
  always_ff @(posedge clock_in)
    if (!rst_in) begin
      cfg_q <= '{pattern: DEF_PAT, len: DEF_LEN, overlap: DEF_OVERLAP};
      hist <= '0;
      fill <= '0;
      match_out <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      match_out <= take;
      cfg_err <= cfg_load && !len_ok;
      // a load always consumes the cycle; a coincident data bit is dropped
      if (cfg_load) begin
        if (len_ok) begin
          cfg_q <= '{pattern: PAT_W'(cfg_pattern), len: CFG_LEN_W'(cfg_len), overlap: cfg_overlap};
          hist <= '0;
          fill <= '0;
        end
      end else if (data_valid) begin
        hist <= nxt;
        fill <= (hit && !cfg_q.overlap) ? '0 : fill_inc;
      end
    end
  seq_det_sat_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clock_in(clock_in),
    .rst_in  (rst_in),
    .clr     (cnt_clr),
    .inc     (take),
    .count   (match_count)
  );
endmodule

// File: tb/tb_seq_det_prog.sv
// tb_seq_det_prog: scoreboard bench for seq_det_prog (MAX_LEN=8, CNT_W=8 and CNT_W=2 instances)
module tb_seq_det_prog;
  logic clock_in = 0, rst_in = 0, cfg_load = 0, cfg_overlap = 0, data_valid = 0, data_in = 0, cnt_clr = 0;
  logic [7:0] cfg_pattern = '0;
  logic [3:0] cfg_len = '0;
  logic cfg_err, match_out, cfg_err2, match_out2;
  logic [7:0] match_count;
  logic [1:0] match_count2;
  typedef struct {logic m; logic e; logic [7:0] c1; logic [1:0] c2;} exp_t;
  exp_t q[$];
  logic [7:0] c1 = 0;
  logic [1:0] c2 = 0;
  int total = 0, bad = 0;
  always #5 clock_in = ~clock_in;
  seq_det_prog #(.MAX_LEN(8), .CNT_W(8)) dut (
    .clock_in(clock_in), .rst_in(rst_in), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_err(cfg_err), .data_valid(data_valid),
    .data_in(data_in), .match_out(match_out), .cnt_clr(cnt_clr), .match_count(match_count));
  seq_det_prog #(.MAX_LEN(8), .CNT_W(2)) dut2 (
    .clock_in(clock_in), .rst_in(rst_in), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_err(cfg_err2), .data_valid(data_valid),
    .data_in(data_in), .match_out(match_out2), .cnt_clr(cnt_clr), .match_count(match_count2));
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, req);
    end
  endtask
  always @(posedge clock_in) begin
    #1;
    if (q.size() != 0) begin
      exp_t x;
      x = q.pop_front();
      chk("match_out", {7'd0, match_out}, {7'd0, x.m});
      chk("cfg_err", {7'd0, cfg_err}, {7'd0, x.e});
      chk("match_count", match_count, x.c1);
      chk("match_out2", {7'd0, match_out2}, {7'd0, x.m});
      chk("match_count2", {6'd0, match_count2}, {6'd0, x.c2});
    end
  end
  task automatic cyc(input logic rst, ld, v, d, clr, input logic [7:0] p, input logic [3:0] l,
                     input logic ov, em, ee);
    @(negedge clock_in);
    rst_in = rst; cfg_load = ld; data_valid = v; data_in = d; cnt_clr = clr;
    cfg_pattern = p; cfg_len = l; cfg_overlap = ov;
    if (!rst || clr) begin c1 = 0; c2 = 0; end
    else if (em) begin
      if (c1 != 8'hff) c1 = c1 + 1;
      if (c2 != 2'd3) c2 = c2 + 1;
    end
    q.push_back('{m: em, e: ee, c1: c1, c2: c2});
  endtask
  task automatic bitc(input logic d, clr, em);
    cyc(1, 0, 1, d, clr, 8'h0, 4'd0, 0, em, 0);
  endtask
  task automatic idle(input logic clr);
    cyc(1, 0, 0, 0, clr, 8'h0, 4'd0, 0, 0, 0);
  endtask
  task automatic load(input logic [7:0] p, input logic [3:0] l, input logic ov, v, d, ee);
    cyc(1, 1, v, d, 0, p, l, ov, 0, ee);
  endtask
  task automatic rst_cyc();
    cyc(0, 0, 0, 0, 0, 8'h0, 4'd0, 0, 0, 0);
  endtask
  initial begin
    int k;
    rst_cyc(); rst_cyc();
    // default overlapping 101
    bitc(1, 0, 0); bitc(0, 0, 0); bitc(1, 0, 1); bitc(0, 0, 0); bitc(1, 0, 1);
    idle(0);
    bitc(0, 0, 0); idle(0); bitc(1, 0, 1); idle(0);
    // 1101 non-overlapping
    idle(1);
    load(8'b1101, 4'd4, 0, 0, 0, 0);
    bitc(1, 0, 0); bitc(1, 0, 0); bitc(0, 0, 0); bitc(1, 0, 1);
    bitc(1, 0, 0); bitc(0, 0, 0); bitc(1, 0, 0);
    // 1101 overlapping
    idle(1);
    load(8'b1101, 4'd4, 1, 0, 0, 0);
    bitc(1, 0, 0); bitc(1, 0, 0); bitc(0, 0, 0); bitc(1, 0, 1);
    bitc(1, 0, 0); bitc(0, 0, 0); bitc(1, 0, 1);
    // illegal lengths keep config and history
    load(8'hff, 4'd0, 0, 0, 0, 1);
    load(8'hff, 4'd9, 0, 0, 0, 1);
    bitc(1, 0, 0); bitc(0, 0, 0); bitc(1, 0, 1);
    // len=1, saturation on the 2-bit counter
    load(8'b1, 4'd1, 0, 0, 0, 0);
    idle(1);
    bitc(1, 0, 1); bitc(1, 0, 1); bitc(1, 0, 1); bitc(1, 0, 1); bitc(1, 0, 1);
    bitc(0, 0, 0);
    // clear wins over coincident hit
    bitc(1, 1, 1); bitc(1, 0, 1);
    // reset mid-stream
    load(8'b101, 4'd3, 1, 0, 0, 0);
    bitc(1, 0, 0); bitc(0, 0, 0);
    rst_cyc();
    bitc(1, 0, 0); bitc(0, 0, 0); bitc(1, 0, 1);
    // load with coincident data bit: bit dropped, fill restarts
    load(8'b11, 4'd2, 1, 1, 1, 0);
    bitc(1, 0, 0); bitc(1, 0, 1); bitc(1, 0, 1);
    load(8'b11, 4'd2, 1, 0, 0, 0);
    idle(0);
    k = 0;
    while (q.size() != 0 && k < 10) begin @(posedge clock_in); k++; end
    #3;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
